// File: rtl/conf_regs_obi_responder_pkg.sv
// rtl/conf_regs_obi_responder_pkg.sv - e-GPU configuration register offsets, register struct, responder states
// Shared by the conf_regs responder and its OBI handshake sub-module.
package e_gpu_conf_pkg;

  localparam logic [5:0] OFF_VERSION   = 6'h00;
  localparam logic [5:0] OFF_STATUS    = 6'h04;
  localparam logic [5:0] OFF_IRQ_EN    = 6'h08;
  localparam logic [5:0] OFF_KERNEL_PC = 6'h0C;
  localparam logic [5:0] OFF_ARG0      = 6'h10;
  localparam logic [5:0] OFF_ARG1      = 6'h14;
  localparam logic [5:0] OFF_ARG2      = 6'h18;
  localparam logic [5:0] OFF_START     = 6'h1C;
  localparam logic [5:0] OFF_DONE      = 6'h20;

  localparam int N_ARGS = 3;

  typedef struct packed {
    logic                     irq_en;
    logic [31:0]              kernel_pc;
    logic [N_ARGS-1:0][31:0]  arg;
    logic                     busy;
    logic                     start_err;
    logic                     done;
  } conf_regs_t;

  typedef enum logic {IDLE, RESP} resp_state_e;

  // Replace only the byte lanes selected by be.
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = new_v[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/conf_regs_obi_responder_if.sv
// rtl/conf_regs_obi_responder_if.sv - OBI request/response bundle for the conf_regs port
// Signal names match the OBI responder port list; slave is the responder side.
interface conf_regs_obi_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_i;
  logic              we_i;
  logic [3:0]        be_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              gnt_o;
  logic              rvalid_o;
  logic [DATA_W-1:0] rdata_o;

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/conf_regs_obi_responder_obi_slave_handshake.sv
// rtl/conf_regs_obi_responder_obi_slave_handshake.sv - zero-wait-state OBI grant/rvalid FSM with registered rdata
// Reusable by any single-outstanding OBI responder; the caller supplies the read data for the accepted request.
module obi_slave_handshake
  import e_gpu_conf_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [DATA_W-1:0] rdata_next,
  output logic              gnt,
  output logic              accept,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);

  resp_state_e state, state_next;

  assign gnt    = req;
  assign accept = req;
  assign rvalid = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RESP;
      RESP:    state_next = accept ? RESP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // rdata is zero whenever no response is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rdata <= '0;
    else if (accept) rdata <= rdata_next;
    else             rdata <= '0;
  end

endmodule

// File: rtl/conf_regs_obi_responder.sv
// rtl/conf_regs_obi_responder.sv - e-GPU configuration register bank OBI responder
// Optional irq_o output enabled by defining CONF_REGS_IRQ_EN.
module conf_regs_obi_responder
  import e_gpu_conf_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter logic [31:0] VERSION = 32'h0001_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  conf_regs_obi_responder_if.slave bus,
  output logic [31:0]             kernel_pc_o,
  output logic [N_ARGS-1:0][31:0] arg_o,
  output logic                    start_o,
  input  logic                    done_i
`ifdef CONF_REGS_IRQ_EN
  ,
  output logic                    irq_o
`endif
);

  conf_regs_t        regs, regs_next;
  logic [ADDR_W-1:0] addr;
  logic [5:0]        off;
  logic [DATA_W-1:0] rd_next;
  logic              accept, addr_ok, wr, start_req, start_ok, done_clr;

  obi_slave_handshake #(.DATA_W(DATA_W)) u_handshake (
    .clk        (clk_i),
    .rst        (rst_i),
    .req        (bus.req_i),
    .rdata_next (rd_next),
    .gnt        (bus.gnt_o),
    .accept     (accept),
    .rvalid     (bus.rvalid_o),
    .rdata      (bus.rdata_o)
  );

  assign addr      = bus.addr_i;
  assign off       = addr[5:0];
  assign addr_ok   = (addr[1:0] == 2'b00) && (addr <= ADDR_W'(OFF_DONE));
  assign wr        = accept && bus.we_i && addr_ok;
  assign start_req = wr && (off == OFF_START) && bus.be_i[0] && bus.wdata_i[0];
  // A done_i in the same cycle frees the controller before the START is judged.
  assign start_ok  = start_req && (!regs.busy || done_i);
  assign done_clr  = wr && (off == OFF_DONE) && bus.be_i[0] && bus.wdata_i[0];

  always_comb begin
    rd_next = '0;
    if (accept && !bus.we_i && addr_ok) begin
      case (off)
        OFF_VERSION:   rd_next = VERSION;
        OFF_STATUS:    rd_next = {30'b0, regs.start_err, regs.busy};
        OFF_IRQ_EN:    rd_next = {31'b0, regs.irq_en};
        OFF_KERNEL_PC: rd_next = regs.kernel_pc;
        OFF_ARG0:      rd_next = regs.arg[0];
        OFF_ARG1:      rd_next = regs.arg[1];
        OFF_ARG2:      rd_next = regs.arg[2];
        OFF_DONE:      rd_next = {31'b0, regs.done};
        default:       rd_next = '0;
      endcase
    end
  end

  always_comb begin
    regs_next = regs;
    if (wr) begin
      case (off)
        OFF_IRQ_EN:    if (bus.be_i[0]) regs_next.irq_en = bus.wdata_i[0];
        OFF_KERNEL_PC: regs_next.kernel_pc = be_merge(regs.kernel_pc, bus.wdata_i, bus.be_i);
        OFF_ARG0:      regs_next.arg[0] = be_merge(regs.arg[0], bus.wdata_i, bus.be_i);
        OFF_ARG1:      regs_next.arg[1] = be_merge(regs.arg[1], bus.wdata_i, bus.be_i);
        OFF_ARG2:      regs_next.arg[2] = be_merge(regs.arg[2], bus.wdata_i, bus.be_i);
        default:       ;
      endcase
    end
    // Order matters: W1C, then done_i set, then an accepted START.
    if (done_clr) regs_next.done = 1'b0;
    if (done_i) begin
      regs_next.done = 1'b1;
      regs_next.busy = 1'b0;
    end
    if (start_ok) begin
      regs_next.busy = 1'b1;
      regs_next.done = 1'b0;
    end
    if (start_req && !start_ok) regs_next.start_err = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      regs    <= '0;
      start_o <= 1'b0;
    end else begin
      regs    <= regs_next;
      start_o <= start_ok;
    end
  end

`ifdef CONF_REGS_IRQ_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq_o <= 1'b0;
    else       irq_o <= regs_next.done & regs_next.irq_en;
  end
`endif

  assign kernel_pc_o = regs.kernel_pc;
  assign arg_o       = regs.arg;

endmodule

// File: tb/tb_conf_regs_obi_responder.sv
// tb/tb_conf_regs_obi_responder.sv - scoreboard bench for the conf_regs OBI responder
// Expected read data is queued at request time and popped when rvalid_o appears.
module tb_conf_regs_obi_responder;
  import e_gpu_conf_pkg::*;

  logic                    clk;
  logic                    rst;
  logic                    done_i;
  logic [31:0]             kernel_pc;
  logic [N_ARGS-1:0][31:0] arg;
  logic                    start;
`ifdef CONF_REGS_IRQ_EN
  logic                    irq;
`endif

  conf_regs_obi_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  conf_regs_obi_responder #(
    .ADDR_W (32),
    .DATA_W (32),
    .VERSION(32'h0001_0000)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .kernel_pc_o (kernel_pc),
    .arg_o       (arg),
    .start_o     (start),
    .done_i      (done_i)
`ifdef CONF_REGS_IRQ_EN
    ,
    .irq_o       (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rvalid_o) begin
        if (sb.size() == 0) check("unexpected_rvalid", 32'd1, 32'd0);
        else check("rdata", bus.rdata_o, sb.pop_front());
      end else begin
        check("rdata_idle_zero", bus.rdata_o, 32'd0);
      end
    end
  end

  task automatic obi(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input logic [31:0] exp, input bit with_done = 1'b0);
    @(negedge clk);
    done_i      = with_done;
    bus.req_i   = 1'b1;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.wdata_i = wdata;
    bus.be_i    = be;
    sb.push_back(we ? 32'd0 : exp);
    #1 check("gnt_same_cycle", {31'b0, bus.gnt_o}, 32'd1);
  endtask

  task automatic idle(input bit with_done = 1'b0);
    @(negedge clk);
    bus.req_i = 1'b0;
    bus.we_i  = 1'b0;
    done_i    = with_done;
  endtask

  logic [31:0] b2b_exp [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; done_i = 1'b0;
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.be_i = 4'h0; bus.addr_i = '0; bus.wdata_i = '0;

    // Reset
    repeat (5) @(negedge clk);
    check("reset_rvalid", {31'b0, bus.rvalid_o}, 32'd0);
    check("reset_start", {31'b0, start}, 32'd0);
    rst = 1'b0;
    obi(1'b0, 32'h0C, 32'h0, 4'hF, 32'h0);
    obi(1'b0, 32'h00, 32'h0, 4'hF, 32'h0001_0000);
    idle();

    // Program
    obi(1'b1, 32'h0C, 32'h8000, 4'hF, 32'h0);
    idle(); check("wr_rvalid_next", {31'b0, bus.rvalid_o}, 32'd1);
    obi(1'b1, 32'h10, 32'h0, 4'hF, 32'h0);
    obi(1'b1, 32'h14, 32'h0, 4'hF, 32'h0);
    obi(1'b1, 32'h18, 32'h0, 4'hF, 32'h0);
    idle(); check("wr_rvalid_b2b", {31'b0, bus.rvalid_o}, 32'd1);
    check("kernel_pc_o", kernel_pc, 32'h8000);
    obi(1'b0, 32'h0C, 32'h0, 4'hF, 32'h8000);
    obi(1'b0, 32'h10, 32'h0, 4'hF, 32'h0);
    obi(1'b0, 32'h14, 32'h0, 4'hF, 32'h0);
    obi(1'b0, 32'h18, 32'h0, 4'hF, 32'h0);

    // Start / done
    obi(1'b1, 32'h1C, 32'h1, 4'hF, 32'h0);
    idle(); check("start_pulse", {31'b0, start}, 32'd1);
    @(negedge clk); check("start_one_cycle", {31'b0, start}, 32'd0);
    obi(1'b0, 32'h04, 32'h0, 4'hF, 32'h1);
    idle(1'b1);
    idle();
    obi(1'b0, 32'h04, 32'h0, 4'hF, 32'h0);
    obi(1'b0, 32'h20, 32'h0, 4'hF, 32'h1);
    obi(1'b1, 32'h20, 32'h1, 4'hF, 32'h0);
    obi(1'b0, 32'h20, 32'h0, 4'hF, 32'h0);

    // Collisions: START while busy, done_i with W1C, done_i with START
    obi(1'b1, 32'h1C, 32'h1, 4'hF, 32'h0);
    obi(1'b1, 32'h1C, 32'h1, 4'hF, 32'h0);
    idle(); check("start_while_busy", {31'b0, start}, 32'd0);
    obi(1'b0, 32'h04, 32'h0, 4'hF, 32'h3);
    obi(1'b1, 32'h20, 32'h1, 4'hF, 32'h0, 1'b1);
    obi(1'b0, 32'h20, 32'h0, 4'hF, 32'h1);
    obi(1'b0, 32'h04, 32'h0, 4'hF, 32'h2);
    obi(1'b1, 32'h1C, 32'h1, 4'hF, 32'h0);
    obi(1'b1, 32'h1C, 32'h1, 4'hF, 32'h0, 1'b1);
    idle(); check("start_after_done", {31'b0, start}, 32'd1);
    obi(1'b0, 32'h04, 32'h0, 4'hF, 32'h3);
    obi(1'b0, 32'h20, 32'h0, 4'hF, 32'h0);
    idle(1'b1);

    // Byte enables and bad addresses
    obi(1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, 32'h0);
    obi(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 32'h0);
    obi(1'b0, 32'h10, 32'h0, 4'hF, 32'h00BB_00DD);
    obi(1'b1, 32'h24, 32'h1234_5678, 4'hF, 32'h0);
    obi(1'b0, 32'h24, 32'h0, 4'hF, 32'h0);
    obi(1'b1, 32'h0E, 32'h1234_5678, 4'hF, 32'h0);
    obi(1'b0, 32'h0E, 32'h0, 4'hF, 32'h0);
    obi(1'b0, 32'h0C, 32'h0, 4'hF, 32'h8000);
    obi(1'b0, 32'h1C, 32'h0, 4'hF, 32'h0);
    idle();
    check("arg0_o", arg[0], 32'h00BB_00DD);

    // Back-to-back reads
    b2b_exp = '{32'h0001_0000, 32'h2, 32'h0, 32'h8000, 32'h00BB_00DD, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      obi(1'b0, 32'(4 * i), 32'h0, 4'hF, b2b_exp[i]);
      if (i > 0) check("b2b_rvalid", {31'b0, bus.rvalid_o}, 32'd1);
    end
    idle(); check("b2b_last_rvalid", {31'b0, bus.rvalid_o}, 32'd1);
    @(negedge clk);

    // Reset while a response is pending
    obi(1'b0, 32'h00, 32'h0, 4'hF, 32'h0001_0000);
    @(posedge clk);
    #1 rst = 1'b1; bus.req_i = 1'b0;
    @(negedge clk); check("rst_drops_rvalid", {31'b0, bus.rvalid_o}, 32'd0);
    @(negedge clk); check("rst_no_late_rvalid", {31'b0, bus.rvalid_o}, 32'd0);
    sb.delete();
    rst = 1'b0;
    @(negedge clk); check("post_rst_rvalid", {31'b0, bus.rvalid_o}, 32'd0);
    obi(1'b0, 32'h0C, 32'h0, 4'hF, 32'h0);
    obi(1'b0, 32'h04, 32'h0, 4'hF, 32'h0);

`ifdef CONF_REGS_IRQ_EN
    obi(1'b1, 32'h08, 32'h1, 4'hF, 32'h0);
    idle(1'b1);
    idle(); check("irq_set", {31'b0, irq}, 32'd1);
    obi(1'b1, 32'h20, 32'h1, 4'hF, 32'h0);
    idle(); check("irq_clear", {31'b0, irq}, 32'd0);
`endif

    idle();
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
